pio_event_sequencer: RTL and testbench
======================================

Name: pio_event_sequencer

Overview:
- Avalon-MM master that owns the 18-bit switch PIO: programs its irq_mask, services its edge interrupt, and queues one event record per service in a local FIFO.
- Each service reads edge_capture, reads the live input value, then clears edge_capture.
- Sits between the switch PIO slave port and a consumer (Nios-side bridge or hardware logic) that drains events with a valid/ready handshake.
- Also arbitrates runtime mask updates from the consumer against interrupt servicing.

Parameters:
- W, 18, PIO data width (edge_capture, data, mask).
- DEPTH, 8, event FIFO depth (power of 2, >=2).
- MASK_INIT, 18'h3FFFF, irq_mask written once after reset.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- pio_irq  in  1  PIO interrupt (|(edge_capture & irq_mask))
- pio_chipselect  out  1  PIO chipselect
- pio_write_n  out  1  PIO write strobe, active-low
- pio_address  out  2  PIO register: 0 data, 2 irq_mask, 3 edge_capture
- pio_writedata  out  W  PIO write data
- pio_readdata  in  W  PIO read data; registered in the slave, valid the cycle after the address is presented
- cfg_mask_valid  in  1  mask update request
- cfg_mask  in  W  new irq_mask value
- cfg_mask_ready  out  1  one-cycle pulse: the mask write has been issued
- evt_valid  out  1  FIFO non-empty
- evt_ready  in  1  consumer pops the event when evt_valid=1
- evt_capture  out  W  head event: edge_capture snapshot
- evt_data  out  W  head event: data register snapshot
- evt_count  out  log2(DEPTH)+1  FIFO occupancy
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset values: all outputs registered. pio_chipselect=0, pio_write_n=1, pio_address=0, pio_writedata=0, cfg_mask_ready=0, evt_valid=0, evt_count=0, busy=1 (FSM enters INIT). FIFO is emptied. Reset mid-transaction aborts the transaction with no partial push.
- Bus idle value: chipselect=0, write_n=1, address=0.
- Each bus access lasts exactly one cycle. Write cycles: cs=1, write_n=0. Read cycles: cs=1, write_n=1.
- FSM states and transitions:
  - INIT: write addr 2 with MASK_INIT -> IDLE.
  - IDLE: cfg_mask_valid has priority -> WR_MASK. Otherwise, if pio_irq=1 and evt_count<DEPTH -> RD_CAP. Otherwise stay.
  - WR_MASK: write addr 2 with cfg_mask; pulse cfg_mask_ready in this cycle -> IDLE.
  - RD_CAP: read addr 3 -> CAP_WAIT.
  - CAP_WAIT: address 0 with cs=1 (data read issued); latch pio_readdata into cap_reg -> DATA_WAIT.
  - DATA_WAIT: bus idle; latch pio_readdata into dat_reg -> CLR.
  - CLR: write addr 3, writedata all-ones (any write clears all bits) -> PUSH.
  - PUSH: enqueue {cap_reg, dat_reg} -> IDLE.
- Service latency: pio_irq high in IDLE to event visible on evt_valid = 6 cycles (RD_CAP through PUSH, valid the cycle after PUSH).
- FIFO full: no service starts. pio_irq stays high and edges accumulate (OR) in edge_capture, so nothing is lost. Service resumes the cycle after a pop drops evt_count below DEPTH.
- Edge window: edges arriving between the RD_CAP sample and the CLR write are cleared without being reported. This is an accepted limitation, bounded to 3 cycles.
- Empty FIFO: evt_ready is ignored.
- Simultaneous push and pop: occupancy is unchanged, and a push into a full FIFO never occurs.
- Pointers wrap modulo DEPTH.
- FIFO output is first-word-fall-through: evt_capture/evt_data show the head entry whenever evt_valid=1.
- cap_reg=0 (spurious irq, e.g. the mask changed mid-service): the event is still pushed.
- A mask update requested during service waits until IDLE. cfg_mask must be held until cfg_mask_ready.

Test Plan:
- Reset release -> cycle 1: cs=1, write_n=0, address=2, writedata=3FFFF. Then bus idle, busy=0.
- Falling edge on bit 5 (in_port 00020->00000), PIO model in loop, evt_ready=0 -> exactly one event, evt_capture=00020, evt_data=00000. Bus sequence: read 3, read 0, write 3. PIO irq deasserts after the CLR write.
- cfg_mask_valid with cfg_mask=00001 asserted on the same cycle pio_irq rises -> WR_MASK issued first with cfg_mask_ready pulse. Service follows only if irq is still asserted under mask 00001.
- evt_ready=0, 9 successive single-bit falling edges (bits 0..8) -> evt_count saturates at 8, pio_irq stays high. One pop -> ninth service runs, and its capture word contains the accumulated bit 8.
- Pop and push on the same cycle at evt_count=3 -> evt_count stays 3, FIFO order preserved.
- reset_n asserted during CAP_WAIT -> FIFO empty, outputs at reset values, INIT mask write reissued after release.

Source files
------------

// File: rtl/pio_event_sequencer.sv
// pio_event_sequencer: Avalon-MM master that services the switch PIO edge interrupt
// and queues {edge_capture, data} snapshots in a first-word-fall-through FIFO.
module pio_event_sequencer #(
  parameter int W = 18,
  parameter int DEPTH = 8,
  parameter logic [W-1:0] MASK_INIT = 18'h3FFFF
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       pio_irq,
  output logic                       pio_chipselect,
  output logic                       pio_write_n,
  output logic [1:0]                 pio_address,
  output logic [W-1:0]               pio_writedata,
  input  logic [W-1:0]               pio_readdata,
  input  logic                       cfg_mask_valid,
  input  logic [W-1:0]               cfg_mask,
  output logic                       cfg_mask_ready,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [W-1:0]               evt_capture,
  output logic [W-1:0]               evt_data,
  output logic [$clog2(DEPTH):0]     evt_count,
  output logic                       busy
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {INIT, IDLE, WR_MASK, RD_CAP, CAP_WAIT, DATA_WAIT, CLR, PUSH} state_t;
  state_t state, state_nx;
  logic cs_nx, wn_nx;
  logic [1:0] addr_nx;
  logic [W-1:0] wd_nx, cap_reg, dat_reg;
  logic [2*W-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count_nx;
  logic push, pop, full;
  assign full = evt_count == (AW+1)'(DEPTH);
  assign push = state == PUSH;
  assign pop = evt_ready && evt_valid;
  assign count_nx = evt_count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  assign evt_capture = mem[rd_ptr][2*W-1:W];
  assign evt_data = mem[rd_ptr][W-1:0];
  // Bus outputs are registered from the next state so they line up with the state they belong to;
  // INIT holds until its own write has been on the bus once.
  always_comb begin
    state_nx = state;
    case (state)
      INIT:      state_nx = pio_chipselect ? IDLE : INIT;
      IDLE:      state_nx = cfg_mask_valid ? WR_MASK : (pio_irq && !full) ? RD_CAP : IDLE;
      WR_MASK:   state_nx = IDLE;
      RD_CAP:    state_nx = CAP_WAIT;
      CAP_WAIT:  state_nx = DATA_WAIT;
      DATA_WAIT: state_nx = CLR;
      CLR:       state_nx = PUSH;
      PUSH:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
    cs_nx = state_nx inside {INIT, WR_MASK, RD_CAP, CAP_WAIT, CLR};
    wn_nx = !(state_nx inside {INIT, WR_MASK, CLR});
    addr_nx = (state_nx inside {INIT, WR_MASK}) ? 2'd2 : (state_nx inside {RD_CAP, CLR}) ? 2'd3 : 2'd0;
    wd_nx = state_nx == INIT ? MASK_INIT : state_nx == WR_MASK ? cfg_mask : state_nx == CLR ? '1 : '0;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= INIT;
      pio_chipselect <= 1'b0;
      pio_write_n <= 1'b1;
      pio_address <= 2'd0;
      pio_writedata <= '0;
      cfg_mask_ready <= 1'b0;
      busy <= 1'b1;
      cap_reg <= '0;
      dat_reg <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      evt_count <= '0;
      evt_valid <= 1'b0;
    end else begin
      state <= state_nx;
      pio_chipselect <= cs_nx;
      pio_write_n <= wn_nx;
      pio_address <= addr_nx;
      pio_writedata <= wd_nx;
      cfg_mask_ready <= state_nx == WR_MASK;
      busy <= state_nx != IDLE;
      if (state == CAP_WAIT) cap_reg <= pio_readdata;
      if (state == DATA_WAIT) dat_reg <= pio_readdata;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      evt_count <= count_nx;
      evt_valid <= count_nx != '0;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cap_reg, dat_reg};
  end
endmodule

// File: tb/tb_pio_event_sequencer.sv
// tb_pio_event_sequencer: PIO slave model plus scoreboard of expected {capture, data} events,
// with directed corner cases followed by randomized switch activity.
module tb_pio_event_sequencer;
  localparam int W = 18;
  localparam int DEPTH = 8;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic pio_irq, pio_chipselect, pio_write_n;
  logic [1:0] pio_address;
  logic [W-1:0] pio_writedata, pio_readdata;
  logic cfg_mask_valid = 1'b0;
  logic [W-1:0] cfg_mask = '0;
  logic cfg_mask_ready, evt_valid, busy;
  logic evt_ready = 1'b0;
  logic [W-1:0] evt_capture, evt_data;
  logic [3:0] evt_count;
  logic [W-1:0] in_port = '0;
  logic [W-1:0] prev, ec, mask_r, nv, fall, v;
  logic [2*W-1:0] sb[$];
  logic [W+2:0] bus_log[$];
  logic [2*W-1:0] e;
  int n_checks = 0;
  int n_fail = 0;
  int t, lat;
  always #5 clk = ~clk;
  pio_event_sequencer #(.W(W), .DEPTH(DEPTH), .MASK_INIT(18'h3FFFF)) dut (
    .clk(clk), .reset_n(reset_n), .pio_irq(pio_irq),
    .pio_chipselect(pio_chipselect), .pio_write_n(pio_write_n), .pio_address(pio_address),
    .pio_writedata(pio_writedata), .pio_readdata(pio_readdata),
    .cfg_mask_valid(cfg_mask_valid), .cfg_mask(cfg_mask), .cfg_mask_ready(cfg_mask_ready),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_capture(evt_capture), .evt_data(evt_data),
    .evt_count(evt_count), .busy(busy)
  );
  // Switch PIO: falling-edge capture, write to edge_capture clears it, registered readdata.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev <= in_port;
      ec <= '0;
      mask_r <= '0;
      pio_readdata <= '0;
    end else begin
      prev <= in_port;
      ec <= ((pio_chipselect && !pio_write_n && pio_address == 2'd3) ? '0 : ec) | (prev & ~in_port);
      if (pio_chipselect && !pio_write_n && pio_address == 2'd2) mask_r <= pio_writedata;
      pio_readdata <= !pio_chipselect ? '0 : pio_address == 2'd0 ? in_port :
                      pio_address == 2'd2 ? mask_r : pio_address == 2'd3 ? ec : '0;
    end
  end
  assign pio_irq = |(ec & mask_r);
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic wait_quiet(input bit rnd);
    int k = 0;
    repeat (2) begin
      if (rnd) evt_ready = 1'($urandom_range(0, 1));
      step();
    end
    while ((pio_irq || busy) && k < 300) begin
      if (rnd) evt_ready = 1'($urandom_range(0, 1));
      step();
      k++;
    end
    chk("service_done", {63'b0, pio_irq || busy}, 64'd0);
  endtask
  task automatic check_reset_vals();
    chk("rst_cs", pio_chipselect, 0);
    chk("rst_write_n", pio_write_n, 1);
    chk("rst_addr", pio_address, 0);
    chk("rst_wdata", pio_writedata, 0);
    chk("rst_ready", cfg_mask_ready, 0);
    chk("rst_valid", evt_valid, 0);
    chk("rst_count", evt_count, 0);
    chk("rst_busy", busy, 1);
  endtask
  task automatic check_init();
    step();
    chk("init_cs", pio_chipselect, 1);
    chk("init_write_n", pio_write_n, 0);
    chk("init_addr", pio_address, 2);
    chk("init_wdata", pio_writedata, 18'h3FFFF);
    step();
    chk("post_init_cs", pio_chipselect, 0);
    chk("post_init_busy", busy, 0);
  endtask
  task automatic drain();
    int k = 0;
    evt_ready = 1'b1;
    while (evt_count != 0 && k < 50) begin
      step();
      k++;
    end
    evt_ready = 1'b0;
    chk("drain_count", evt_count, 0);
  endtask
  initial begin
    fork
      forever begin
        @(negedge clk);
        if (pio_chipselect) bus_log.push_back({pio_write_n, pio_address, pio_writedata});
        if (reset_n && evt_valid && evt_ready) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got %h/%h expected none", evt_capture, evt_data);
          end else begin
            e = sb.pop_front();
            chk("evt_capture", evt_capture, e[2*W-1:W]);
            chk("evt_data", evt_data, e[W-1:0]);
          end
        end
      end
    join_none
    reset_n = 1'b0;
    in_port = 18'h00020;
    repeat (3) step();
    check_reset_vals();
    reset_n = 1'b1;
    check_init();
    // single falling edge on bit 5
    bus_log.delete();
    in_port = '0;
    sb.push_back({18'h00020, 18'h00000});
    t = 0;
    while (!pio_irq && t < 10) begin step(); t++; end
    chk("irq_rise", pio_irq, 1);
    lat = 0;
    while (!evt_valid && lat < 20) begin step(); lat++; end
    chk("latency", lat, 6);
    wait_quiet(0);
    chk("bus_len", bus_log.size(), 3);
    if (bus_log.size() >= 3) begin
      chk("bus_rd_cap", bus_log[0][W+2:W], 3'b111);
      chk("bus_rd_data", bus_log[1][W+2:W], 3'b100);
      chk("bus_clr", bus_log[2], {1'b0, 2'd3, 18'h3FFFF});
    end
    chk("irq_cleared", pio_irq, 0);
    chk("count_one", evt_count, 1);
    // mask update arriving with the interrupt wins
    in_port = 18'h8;
    step(); step();
    in_port = '0;
    step();
    chk("irq_bit3", pio_irq, 1);
    bus_log.delete();
    cfg_mask = 18'h00001;
    cfg_mask_valid = 1'b1;
    t = 0;
    while (!cfg_mask_ready && t < 10) begin step(); t++; end
    chk("mask_ready", cfg_mask_ready, 1);
    chk("mask_wr_n", pio_write_n, 0);
    chk("mask_addr", pio_address, 2);
    chk("mask_wdata", pio_writedata, 18'h00001);
    cfg_mask_valid = 1'b0;
    repeat (10) step();
    chk("masked_bus_len", bus_log.size(), 1);
    chk("masked_irq", pio_irq, 0);
    chk("masked_count", evt_count, 1);
    sb.push_back({18'h00008, 18'h00000});
    cfg_mask = 18'h3FFFF;
    cfg_mask_valid = 1'b1;
    t = 0;
    while (!cfg_mask_ready && t < 10) begin step(); t++; end
    chk("unmask_ready", cfg_mask_ready, 1);
    cfg_mask_valid = 1'b0;
    wait_quiet(0);
    chk("unmask_count", evt_count, 2);
    // fill the FIFO, then one more edge waits in edge_capture
    drain();
    in_port = 18'h1FF;
    wait_quiet(0);
    for (int i = 0; i < 9; i++) begin
      v = in_port & ~(18'(1) << i);
      sb.push_back({18'(1) << i, v});
      in_port = v;
      if (i < 8) wait_quiet(0);
      else repeat (10) step();
    end
    chk("full_count", evt_count, 8);
    chk("full_irq", pio_irq, 1);
    chk("full_busy", busy, 0);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    wait_quiet(0);
    chk("refill_count", evt_count, 8);
    evt_ready = 1'b1;
    repeat (5) step();
    evt_ready = 1'b0;
    chk("count_three", evt_count, 3);
    // pop lands on the push cycle
    in_port = 18'h3;
    step(); step();
    in_port = 18'h1;
    sb.push_back({18'h00002, 18'h00001});
    t = 0;
    while (!(pio_chipselect && !pio_write_n && pio_address == 2'd3) && t < 20) begin step(); t++; end
    chk("clr_seen", {63'b0, t < 20}, 64'd1);
    step();
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    chk("pushpop_count", evt_count, 3);
    wait_quiet(0);
    // reset in the middle of a service
    in_port = 18'h10;
    step(); step();
    in_port = '0;
    t = 0;
    while (!(pio_chipselect && pio_write_n && pio_address == 2'd0) && t < 20) begin step(); t++; end
    chk("capwait_seen", {63'b0, t < 20}, 64'd1);
    reset_n = 1'b0;
    #1;
    check_reset_vals();
    sb.delete();
    step(); step();
    reset_n = 1'b1;
    check_init();
    chk("post_rst_count", evt_count, 0);
    // random switch activity with a random consumer
    for (int i = 0; i < 40; i++) begin
      nv = 18'($urandom);
      fall = in_port & ~nv;
      if (fall != 0) sb.push_back({fall, nv});
      in_port = nv;
      wait_quiet(1);
    end
    drain();
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
